systolic_row_feeder: RTL
========================

// Module: systolic_row_feeder
// PURPOSE
//  West-edge feeder for the systolic array: accepts one N-lane activation vector per beat
//  (valid/ready) and drives the array row inputs with the classic diagonal skew.
//  Lane i is delayed i extra cycles. Bubbles and the post-burst flush are zero-filled.
//  Sits directly upstream of the first PE pass register of every row; a_data[i] feeds that row's in_d.
//  Also generates the burst control (busy/done) that the array controller sequences on.
// PARAMETERS
//  N       4   number of array rows / lanes (>=1)
//  D_BW    8   data width per lane, matches PE data width
//  CNT_BW  16  width of accepted-beat counter
// PORTS
//  en_clk     in   1         clock (same enable-gated clock as the PE array)
//  rst        in   1         synchronous, active-high reset
//  start      in   1         1-cycle pulse, begins a burst (honoured only in IDLE)
//  s_valid    in   1         upstream vector valid
//  s_ready    out  1         feeder accepts vector this cycle
//  s_last     in   1         qualifies final vector of burst (sampled with s_valid&&s_ready)
//  s_data     in   N*D_BW    lane i = s_data[i*D_BW +: D_BW]
//  a_data     out  N*D_BW    skewed row data to array, lane i in same slice
//  a_vld      out  N         per-lane valid travelling with a_data
//  busy       out  1         state != IDLE
//  done       out  1         1-cycle pulse: last beat's data is on lane N-1
//  beat_cnt   out  CNT_BW    vectors accepted in current/last burst
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE; all delay-line regs, a_data, a_vld, beat_cnt and drain_cnt
//    are cleared to 0. Outputs are therefore s_ready=0, busy=0, done=0.
//    Reset mid-burst aborts the burst silently: no done, and in-flight data is discarded.
//  - FSM IDLE -> STREAM on start. STREAM -> DRAIN on accept && s_last.
//    DRAIN -> IDLE when drain_cnt==0. start is ignored outside IDLE.
//  - s_ready = (state==STREAM), combinational from the state register; it does not depend on s_valid.
//  - accept = s_valid && s_ready. In IDLE/DRAIN, s_valid is never accepted.
//    This includes a start and s_valid arriving in the same cycle.
//  - Every cycle, all lanes shift regardless of accept; the array never stalls.
//    Lane i stage 0 loads s_data lane i with vld=1 on accept, otherwise 0 with vld=0 (bubble/flush).
//  - Latency: a vector accepted at edge e appears on lane i after edge e+i. Lane 0 is registered only.
//    Lane i uses i+1 registers in total. a_vld[i] is delayed identically.
//  - On the edge accepting s_last: drain_cnt <= N-1. In DRAIN, drain_cnt decrements each edge.
//  - done = (state==DRAIN && drain_cnt==0), decoded from registers only, high exactly 1 cycle.
//    That cycle coincides with the last vector on a_data[N-1]. The next edge returns to IDLE.
//    For N=1, done is high in the cycle right after the last accept.
//  - beat_cnt: cleared on start (IDLE), +1 per accept, saturates at 2^CNT_BW-1, held in IDLE until next start.
//  - No arithmetic on data. Zero fill equals the PE reset value, so flushed cycles add nothing to MAC sums.
// STRUCTURE
//  - Shared package systolic_pkg: D_BW default, N default, FSM state encoding
//    (ST_IDLE=2'd0, ST_STREAM=2'd1, ST_DRAIN=2'd2), and a lane slice helper macro/function.
//  - Sub-module skew_delay_line #(DEPTH, D_BW): DEPTH-stage shift register of {vld, data} with
//    sync active-high clear. Instantiated by generate-for with DEPTH=i+1 for lane i.
//  - Top level holds the FSM, drain_cnt ($clog2(N)+1 bits), beat_cnt and stage-0 bubble mux.
// TESTING
//  1 Reset: hold rst 3 cycles mid-STREAM with N=4 -> a_data=0, a_vld=0, busy=0, no done, beat_cnt=0.
//  2 Single beat N=4: start, then s_data={4,3,2,1} with s_last at edge e.
//    -> lane i=i+1 after edge e+i, a_vld one-hot per lane; done only after edge e+3; IDLE after e+4.
//  3 Back-to-back 3 beats, s_valid tied 1 -> continuous diagonal, beat_cnt=3, done 3 cycles after last accept.
//  4 Bubble: s_valid low for 2 cycles mid-burst -> 2-cycle zero/vld=0 hole propagating diagonally; counts exclude it.
//  5 Ignored inputs: start during STREAM/DRAIN and s_valid in IDLE/DRAIN -> s_ready=0, no state or beat_cnt change.
//  6 N=1 corner + saturation: CNT_BW=2, 5 beats -> beat_cnt=3; done in cycle after last accept.

Source files
------------

// File: rtl/systolic_row_feeder_pkg.sv
// systolic_pkg: shared defaults, feeder FSM encoding and lane slicing helper.
package systolic_pkg;
    localparam int N_DEF = 4;
    localparam int D_BW_DEF = 8;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_STREAM = 2'd1, ST_DRAIN = 2'd2} state_t;
    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction
endpackage

// File: rtl/systolic_row_feeder_skew.sv
// skew_delay_line: DEPTH-stage shift register of {vld, data} with synchronous clear.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int D_BW  = 8
) (
    input  logic            en_clk,
    input  logic            clr_i,
    input  logic            vld_i,
    input  logic [D_BW-1:0] data_i,
    output logic            vld_o,
    output logic [D_BW-1:0] data_o
);
    logic [DEPTH-1:0]           vld_q;
    logic [DEPTH-1:0][D_BW-1:0] data_q;
    always_ff @(posedge en_clk) begin
        if (clr_i) begin
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q[0]  <= vld_i;
            data_q[0] <= data_i;
            for (int k = 1; k < DEPTH; k++) begin
                vld_q[k]  <= vld_q[k-1];
                data_q[k] <= data_q[k-1];
            end
        end
    end
    assign vld_o  = vld_q[DEPTH-1];
    assign data_o = data_q[DEPTH-1];
endmodule

// File: rtl/systolic_row_feeder.sv
// systolic_row_feeder: diagonally skews accepted activation vectors onto the array rows
// and sequences burst control (busy/done/beat count).
module systolic_row_feeder
    import systolic_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int D_BW   = D_BW_DEF,
    parameter int CNT_BW = 16
) (
    input  logic                en_clk,
    input  logic                rst,
    input  logic                start,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic                s_last,
    input  logic [N*D_BW-1:0]   s_data,
    output logic [N*D_BW-1:0]   a_data,
    output logic [N-1:0]        a_vld,
    output logic                busy,
    output logic                done,
    output logic [CNT_BW-1:0]   beat_cnt
);
    localparam int DW = $clog2(N) + 1;
    state_t            state_q, state_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic [CNT_BW-1:0] beat_q, beat_d;
    logic              accept;
    assign s_ready  = state_q == ST_STREAM;
    assign accept   = s_valid && s_ready;
    assign busy     = state_q != ST_IDLE;
    assign done     = state_q == ST_DRAIN && drain_q == '0;
    assign beat_cnt = beat_q;
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        beat_d  = beat_q;
        if (state_q == ST_IDLE && start) begin
            state_d = ST_STREAM;
            beat_d  = '0;
        end
        if (accept) begin
            beat_d = &beat_q ? beat_q : beat_q + CNT_BW'(1);
            if (s_last) begin
                state_d = ST_DRAIN;
                drain_d = DW'(N - 1);
            end
        end
        if (state_q == ST_DRAIN) begin
            state_d = drain_q == '0 ? ST_IDLE : ST_DRAIN;
            drain_d = drain_q == '0 ? drain_q : drain_q - DW'(1);
        end
    end
    always_ff @(posedge en_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            beat_q  <= beat_d;
        end
    end
    // Non-accepted cycles inject zero bubbles so flushed slots add nothing to PE sums.
    for (genvar g = 0; g < N; g++) begin : g_lane
        logic [D_BW-1:0] in_d;
        assign in_d = accept ? s_data[lane_lo(g, D_BW) +: D_BW] : '0;
        skew_delay_line #(.DEPTH(g + 1), .D_BW(D_BW)) u_dl (
            .en_clk (en_clk),
            .clr_i  (rst),
            .vld_i  (accept),
            .data_i (in_d),
            .vld_o  (a_vld[g]),
            .data_o (a_data[lane_lo(g, D_BW) +: D_BW])
        );
    end
endmodule
